// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequential shift-add multiplier with EX-stage stall control.
// One product bit per cycle; low WIDTH bits of the product are returned.
module mul_seq_ctrl #(
  parameter int         WIDTH    = 32,
  parameter logic [2:0] MUL_CODE = 3'b100
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic             last_it;
  logic             step;
  logic [WIDTH-1:0] acc_nxt;

  assign accept = (state_q == IDLE) && start_i
                  && (ALUCtrl_i == MUL_CODE) && !flush_i;
  assign last_it = (cnt_q == LAST);
  assign step = (state_q == RUN) && !flush_i;
  assign acc_nxt = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign result_o = res_q;

  // State register; reset and flush both land in IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; flush overrides everything.
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    valid_o = 1'b0;
    busy_o  = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          stall_o = 1'b1;
        end
      end
      RUN: begin
        stall_o = 1'b1;
        if (last_it) begin
          state_d = DONE;
        end
      end
      DONE: begin
        valid_o = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush_i) begin
      state_d = IDLE;
      stall_o = 1'b0;
      valid_o = 1'b0;
    end
    if (rst_i) begin
      stall_o = 1'b0;
      valid_o = 1'b0;
    end
  end

  // Shift-add datapath; the count saturates on the last iteration.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
    end else if (accept) begin
      mcand_q  <= data1_i;
      mplier_q <= data2_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (last_it) begin
        res_q <= acc_nxt;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed bench for the sequential multiplier.
// Inputs change 1 time unit after the rising edge; outputs sampled 1 unit later.
module tb_mul_seq_ctrl;

  localparam logic [2:0] MUL = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  ctrl;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;

  mul_seq_ctrl #(.WIDTH(32), .MUL_CODE(MUL)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .ALUCtrl_i (ctrl),
    .data1_i   (data1),
    .data2_i   (data2),
    .flush_i   (flush),
    .stall_o   (stall),
    .busy_o    (busy),
    .valid_o   (valid),
    .result_o  (result)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply at cycle 0 and observe 38 cycles.
  // start/MUL stay asserted through DONE to show they are ignored.
  task automatic issue_mul(input logic [31:0] a, input logic [31:0] b,
                           output int stall_n, output int valid_at,
                           output int valid_n, output logic [31:0] res,
                           output logic busy_at_valid);
    stall_n = 0;
    valid_at = -1;
    valid_n = 0;
    res = 'x;
    busy_at_valid = 1'b0;
    start = 1'b1;
    ctrl = MUL;
    data1 = a;
    data2 = b;
    for (int c = 0; c < 38; c++) begin
      #1;
      if (stall) stall_n++;
      if (valid) begin
        valid_n++;
        valid_at = c;
        res = result;
        busy_at_valid = busy;
      end
      @(posedge clk);
      #1;
      if (c + 1 <= 32) begin
        data1 = $urandom;
        data2 = $urandom;
      end
      if (c + 1 >= 34) start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    ctrl = 3'b000;
    data1 = '0;
    data2 = '0;
    flush = 1'b0;
    #3;
    vectors++;
    if ({stall, busy, valid, result} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got s%b b%b v%b r%h required all 0",
               stall, busy, valid, result);
    end
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    vectors++;
    if ({stall, busy, valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_release: got s%b b%b v%b required 000",
               stall, busy, valid);
    end
    next_cycle();
  endtask

  task automatic test_basic();
    int sn, va, vn;
    logic [31:0] r;
    logic bv;
    issue_mul(32'd7, 32'd6, sn, va, vn, r, bv);
    vectors++;
    if (sn !== 33) begin
      miscompares++;
      $display("FAIL basic_stall_len: got %0d required 33", sn);
    end
    vectors++;
    if (va !== 33 || vn !== 1) begin
      miscompares++;
      $display("FAIL basic_valid_at: got cyc %0d n %0d required cyc 33 n 1",
               va, vn);
    end
    vectors++;
    if (r !== 32'd42) begin
      miscompares++;
      $display("FAIL basic_result: got %0d required 42", r);
    end
    vectors++;
    if (bv !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy_done: got %b required 1", bv);
    end
    vectors++;
    if (result !== 32'd42) begin
      miscompares++;
      $display("FAIL basic_hold: got %0d required 42", result);
    end
  endtask

  task automatic test_wide();
    int sn, va, vn;
    logic [31:0] r;
    logic bv;
    issue_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, sn, va, vn, r, bv);
    vectors++;
    if (r !== 32'h0000_0001 || va !== 33) begin
      miscompares++;
      $display("FAIL wide_ones: got %h at %0d required 00000001 at 33", r, va);
    end
    issue_mul(32'hFFFF_FFFE, 32'd3, sn, va, vn, r, bv);
    vectors++;
    if (r !== 32'hFFFF_FFFA || va !== 33) begin
      miscompares++;
      $display("FAIL wide_neg2x3: got %h at %0d required fffffffa at 33",
               r, va);
    end
    issue_mul(32'h1234_5678, 32'h0000_0000, sn, va, vn, r, bv);
    vectors++;
    if (r !== 32'h0 || va !== 33) begin
      miscompares++;
      $display("FAIL wide_zero: got %h at %0d required 00000000 at 33", r, va);
    end
    issue_mul(32'h0001_0001, 32'h0001_0003, sn, va, vn, r, bv);
    vectors++;
    if (r !== 32'h0004_0003) begin
      miscompares++;
      $display("FAIL wide_wrap: got %h required 00040003", r);
    end
  endtask

  task automatic test_non_mul();
    int bad;
    logic [2:0] codes [7];
    codes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    bad = 0;
    start = 1'b1;
    data1 = 32'd9;
    data2 = 32'd9;
    for (int k = 0; k < 7; k++) begin
      ctrl = codes[k];
      for (int c = 0; c < 5; c++) begin
        #1;
        if (stall || busy || valid) bad++;
        next_cycle();
      end
    end
    ctrl = 3'b010;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (stall || busy || valid) bad++;
      next_cycle();
    end
    start = 1'b0;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL non_mul_idle: got %0d active cycles required 0", bad);
    end
  endtask

  task automatic test_flush();
    int vn, sn, va;
    logic [31:0] r;
    logic bv;
    start = 1'b1;
    ctrl = MUL;
    data1 = 32'd9;
    data2 = 32'd9;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
    end
    flush = 1'b1;
    #1;
    vectors++;
    if ({stall, busy, valid} !== 3'b010) begin
      miscompares++;
      $display("FAIL flush_cycle: got s%b b%b v%b required 010",
               stall, busy, valid);
    end
    next_cycle();
    flush = 1'b0;
    start = 1'b0;
    #1;
    vectors++;
    if ({stall, busy, valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL flush_next: got s%b b%b v%b required 000",
               stall, busy, valid);
    end
    vn = 0;
    for (int c = 0; c < 30; c++) begin
      next_cycle();
      if (valid || busy) vn++;
    end
    vectors++;
    if (vn !== 0) begin
      miscompares++;
      $display("FAIL flush_quiet: got %0d active cycles required 0", vn);
    end
    issue_mul(32'd5, 32'd5, sn, va, vn, r, bv);
    vectors++;
    if (r !== 32'd25 || va !== 33 || vn !== 1) begin
      miscompares++;
      $display("FAIL flush_then_mul: got %0d at %0d n %0d required 25 at 33 n 1",
               r, va, vn);
    end
    start = 1'b1;
    ctrl = MUL;
    flush = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_prio_stall: got %b required 0", stall);
    end
    next_cycle();
    start = 1'b0;
    flush = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_prio_busy: got %b required 0", busy);
    end
    next_cycle();
  endtask

  task automatic test_async_reset();
    int sn, va, vn;
    logic [31:0] r;
    logic bv;
    start = 1'b1;
    ctrl = MUL;
    data1 = 32'd11;
    data2 = 32'd13;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
    end
    start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({stall, busy, valid, result} !== 35'd0) begin
      miscompares++;
      $display("FAIL areset_outputs: got s%b b%b v%b r%h required all 0",
               stall, busy, valid, result);
    end
    next_cycle();
    rst = 1'b0;
    #1;
    vectors++;
    if ({busy, valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL areset_after: got b%b v%b required 00", busy, valid);
    end
    next_cycle();
    issue_mul(32'd3, 32'd4, sn, va, vn, r, bv);
    vectors++;
    if (r !== 32'd12 || va !== 33) begin
      miscompares++;
      $display("FAIL areset_then_mul: got %0d at %0d required 12 at 33", r, va);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int at [2];
    logic [31:0] rv [2];
    n = 0;
    at = '{-1, -1};
    rv = '{32'hx, 32'hx};
    start = 1'b1;
    ctrl = MUL;
    data1 = 32'd2;
    data2 = 32'd3;
    for (int c = 0; c < 72; c++) begin
      #1;
      if (valid) begin
        if (n < 2) begin
          at[n] = c;
          rv[n] = result;
        end
        n++;
      end
      @(posedge clk);
      #1;
      if (c + 1 <= 32) begin
        data1 = $urandom;
        data2 = $urandom;
      end else if (c + 1 <= 34) begin
        data1 = 32'd4;
        data2 = 32'd5;
      end else begin
        start = 1'b0;
        data1 = $urandom;
        data2 = $urandom;
      end
    end
    vectors++;
    if (n !== 2) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d pulses required 2", n);
    end
    vectors++;
    if (at[0] !== 33 || at[1] !== 67) begin
      miscompares++;
      $display("FAIL b2b_timing: got %0d,%0d required 33,67", at[0], at[1]);
    end
    vectors++;
    if (rv[0] !== 32'd6 || rv[1] !== 32'd20) begin
      miscompares++;
      $display("FAIL b2b_results: got %0d,%0d required 6,20", rv[0], rv[1]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wide();
    test_non_mul();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have parameter MUL_CODE, default 3'b100, the ALU control code that selects multiply.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port start_i, input, 1 bit: a valid instruction occupies the EX stage.
REQ-006 SHALL have port ALUCtrl_i, input, 3 bits: ALU control code of the EX instruction.
REQ-007 SHALL have port data1_i, input, WIDTH bits: multiplicand (rs1).
REQ-008 SHALL have port data2_i, input, WIDTH bits: multiplier (rs2).
REQ-009 SHALL have port flush_i, input, 1 bit: pipeline flush; aborts any multiply in progress.
REQ-010 SHALL have port stall_o, output, 1 bit: freezes IF/ID/EX while a multiply is in flight.
REQ-011 SHALL have port busy_o, output, 1 bit: the sequencer is not IDLE.
REQ-012 SHALL have port valid_o, output, 1 bit: result_o holds a completed product this cycle.
REQ-013 SHALL have port result_o, output, WIDTH bits: low WIDTH bits of data1_i*data2_i.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 IDLE: when start_i=1, ALUCtrl_i=MUL_CODE and flush_i=0, SHALL latch data1_i into mcand, data2_i into mplier, clear acc and count, and go to RUN.
REQ-016 IDLE accept cycle: stall_o SHALL be asserted combinationally in that same cycle.
REQ-017 IDLE with any other ALUCtrl_i, or with start_i=0: stall_o=0, valid_o=0, and the state SHALL stay IDLE.
REQ-018 RUN, each cycle: if mplier[0]=1 then acc <= acc+mcand (truncated to WIDTH); mcand <= mcand<<1; mplier <= mplier>>1; count <= count+1.
REQ-019 RUN: after exactly WIDTH iterations (count reaches WIDTH-1 on the final iteration) SHALL go to DONE; there is no early termination.
REQ-020 RUN: stall_o=1 and busy_o=1; start_i, ALUCtrl_i and the data inputs SHALL be ignored.
REQ-021 DONE: valid_o=1, stall_o=0, busy_o=1, result_o=acc; the state SHALL return to IDLE on the next edge and start_i SHALL be ignored in DONE.
REQ-022 Latency: accept at cycle T, RUN for cycles T+1..T+WIDTH, DONE at cycle T+WIDTH+1; stall_o is high for exactly WIDTH+1 cycles.
REQ-023 result_o SHALL hold its last value outside DONE; it is meaningful only while valid_o=1.
REQ-024 Arithmetic SHALL be unsigned shift-add modulo 2^WIDTH, which gives the correct low half for both signed and unsigned operands.
REQ-025 flush_i=1 in any state SHALL force IDLE on the next edge, with no valid_o pulse and stall_o=0 in that cycle; flush takes priority over a new accept.
REQ-026 A multiply in the EX stage back-to-back with the DONE cycle SHALL be accepted in the following IDLE cycle, with no lost instruction.
REQ-027 count SHALL be clog2(WIDTH) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-028 rst_i=1 SHALL immediately force state=IDLE, acc=0, mcand=0, mplier=0, count=0, result_o=0, valid_o=0, stall_o=0 and busy_o=0, regardless of clk_i.
REQ-029 Reset asserted mid-RUN SHALL discard the operation; after release, the next cycle SHALL be IDLE with no valid_o.

Verification
REQ-030 Scenario: data1=7, data2=6, MUL_CODE at T -> stall_o high T..T+32, valid_o=1 with result_o=42 at T+33 only.
REQ-031 Scenario: data1=32'hFFFFFFFF, data2=32'hFFFFFFFF -> result_o=32'h00000001; data1=32'hFFFFFFFE (-2), data2=3 -> 32'hFFFFFFFA.
REQ-032 Scenario: ALUCtrl_i=3'b010 with start_i=1 -> stall_o=0, busy_o=0, valid_o never asserts.
REQ-033 Scenario: flush_i=1 at RUN cycle 10 -> next cycle IDLE, stall_o=0, no valid_o; a new mul 5*5 then yields 25 after 33 cycles.
REQ-034 Scenario: rst_i pulsed asynchronously (between edges) mid-RUN -> all outputs 0 immediately; a following 3*4 yields 12.
REQ-035 Scenario: two consecutive muls (2*3 then 4*5) -> valid pulses 34 cycles apart carrying 6 then 20.
